mii_rx_frame_ring: RTL and testbench

MII_RX_FRAME_RING -- requirements
Module: mii_rx_frame_ring

---
 rtl/mii_net_pkg.sv | 23 ++
 rtl/mii_rx_slot_ram.sv | 35 +++
 rtl/mii_rx_frame_ring.sv | 187 ++++++++++++++++++
 tb/tb_mii_rx_frame_ring.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_net_pkg.sv
// mii_net_pkg -- shared MII receive types, nibble codes and frame flag indices.
// Rev 1.0
`default_nettype none

package mii_net_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      DROP     = 2'd3
   } rx_state_e;

   localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
   localparam logic [3:0] SFD_NIBBLE      = 4'hD;

   localparam int FLAG_TRUNC = 0;
   localparam int FLAG_ODD   = 1;
   localparam int FLAG_RXER  = 2;

endpackage

`default_nettype wire

// File: rtl/mii_rx_slot_ram.sv
// mii_rx_slot_ram -- simple dual-port frame storage, {slot, offset} addressed, registered read.
// Rev 1.0
`default_nettype none

module mii_rx_slot_ram #(
   parameter int NUM_SLOTS  = 4,
   parameter int SLOT_BYTES = 1024,
   localparam int SLOT_W    = $clog2(NUM_SLOTS),
   localparam int OFS_W     = $clog2(SLOT_BYTES)
) (
   input  logic              enet_rx_clk,
   input  logic              wr_en_i,
   input  logic [SLOT_W-1:0] wr_slot_i,
   input  logic [OFS_W-1:0]  wr_offset_i,
   input  logic [7:0]        wr_data_i,
   input  logic [SLOT_W-1:0] rd_slot_i,
   input  logic [OFS_W-1:0]  rd_offset_i,
   output logic [7:0]        rd_data_o
);

   logic [7:0] mem_q [NUM_SLOTS*SLOT_BYTES];
   logic [7:0] rd_data_q;

   always_ff @(posedge enet_rx_clk) begin
      if (wr_en_i) begin
         mem_q[{wr_slot_i, wr_offset_i}] <= wr_data_i;
      end
      rd_data_q <= mem_q[{rd_slot_i, rd_offset_i}];
   end

   assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/mii_rx_frame_ring.sv
// mii_rx_frame_ring -- MII receive capture into a ring of fixed-size frame slots.
// Rev 1.0
`default_nettype none

module mii_rx_frame_ring
   import mii_net_pkg::*;
#(
   parameter int NUM_SLOTS      = 4,
   parameter int SLOT_BYTES     = 1024,
   parameter int STRIP_PREAMBLE = 1,
   localparam int SLOT_W        = $clog2(NUM_SLOTS),
   localparam int OFS_W         = $clog2(SLOT_BYTES),
   localparam int LEN_W         = OFS_W + 1
) (
   input  logic             enet_rx_clk,
   input  logic             i_reset,
   input  logic             i_capture_en,
   input  logic             enet_rx_dv,
   input  logic             enet_rx_er,
   input  logic [3:0]       enet_rx_data,
   output logic             o_frame_valid,
   output logic [LEN_W-1:0] o_frame_len,
   output logic [2:0]       o_frame_flags,
   input  logic [OFS_W-1:0] i_rd_addr,
   output logic [7:0]       o_rd_data,
   input  logic             i_release,
   output logic [15:0]      o_drop_count,
   output logic             o_busy
);

   rx_state_e         state_q, state_d;
   logic              dv_prev_q;
   logic [SLOT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [SLOT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [SLOT_W:0]   occ_q, occ_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [2:0]        flags_q, flags_d;
   logic [3:0]        held_q, held_d;
   logic              phase_q, phase_d;
   logic [LEN_W-1:0]  slot_len_q   [NUM_SLOTS];
   logic [2:0]        slot_flags_q [NUM_SLOTS];

   logic frame_start;
   logic commit;
   logic release_ok;
   logic ram_we;
   logic full;

   assign frame_start = enet_rx_dv && !dv_prev_q;
   assign full        = (occ_q == (SLOT_W+1)'(NUM_SLOTS));
   assign release_ok  = i_release && (occ_q != '0);

   always_comb begin
      state_d    = state_q;
      drop_cnt_d = drop_cnt_q;
      byte_cnt_d = byte_cnt_q;
      flags_d    = flags_q;
      held_d     = held_q;
      phase_d    = phase_q;
      commit     = 1'b0;
      ram_we     = 1'b0;

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               if (!i_capture_en) begin
                  state_d = DROP;
               end else if (full) begin
                  state_d = DROP;
                  if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
               end else begin
                  byte_cnt_d = '0;
                  flags_d    = '0;
                  phase_d    = 1'b0;
                  if (STRIP_PREAMBLE != 0) begin
                     state_d = PREAMBLE;
                  end else begin
                     // Raw mode: the rising-dv nibble is already the low half of byte 0.
                     state_d             = DATA;
                     held_d              = enet_rx_data;
                     phase_d             = 1'b1;
                     flags_d[FLAG_RXER]  = enet_rx_er;
                  end
               end
            end
         end
         PREAMBLE: begin
            if (!enet_rx_dv) begin
               state_d = IDLE;
            end else if (enet_rx_data == SFD_NIBBLE) begin
               state_d = DATA;
               phase_d = 1'b0;
            end else if (enet_rx_data != PREAMBLE_NIBBLE) begin
               state_d = DROP;
            end
         end
         DATA: begin
            if (!enet_rx_dv) begin
               state_d = IDLE;
               commit  = (byte_cnt_q != '0);
            end else begin
               if (enet_rx_er) flags_d[FLAG_RXER] = 1'b1;
               if (!phase_q) begin
                  held_d  = enet_rx_data;
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  if (byte_cnt_q == LEN_W'(SLOT_BYTES)) begin
                     flags_d[FLAG_TRUNC] = 1'b1;
                  end else begin
                     ram_we     = 1'b1;
                     byte_cnt_d = byte_cnt_q + 1'b1;
                  end
               end
            end
         end
         DROP: begin
            if (!enet_rx_dv) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      wr_ptr_d = wr_ptr_q + SLOT_W'(commit);
      rd_ptr_d = rd_ptr_q + SLOT_W'(release_ok);
      occ_d    = occ_q;
      if (commit && !release_ok)      occ_d = occ_q + 1'b1;
      else if (!commit && release_ok) occ_d = occ_q - 1'b1;
   end

   always_ff @(posedge enet_rx_clk) begin
      // Tracked through reset so a frame already running at release is ignored.
      dv_prev_q <= enet_rx_dv;
      if (i_reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         drop_cnt_q <= '0;
         byte_cnt_q <= '0;
         flags_q    <= '0;
         held_q     <= '0;
         phase_q    <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_len_q[i]   <= '0;
            slot_flags_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         drop_cnt_q <= drop_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         flags_q    <= flags_d;
         held_q     <= held_d;
         phase_q    <= phase_d;
         if (commit) begin
            slot_len_q[wr_ptr_q]   <= byte_cnt_q;
            slot_flags_q[wr_ptr_q] <= {flags_q[FLAG_RXER], phase_q, flags_q[FLAG_TRUNC]};
         end
      end
   end

   mii_rx_slot_ram #(
      .NUM_SLOTS  (NUM_SLOTS),
      .SLOT_BYTES (SLOT_BYTES)
   ) u_ram (
      .enet_rx_clk (enet_rx_clk),
      .wr_en_i     (ram_we),
      .wr_slot_i   (wr_ptr_q),
      .wr_offset_i (byte_cnt_q[OFS_W-1:0]),
      .wr_data_i   ({enet_rx_data, held_q}),
      .rd_slot_i   (rd_ptr_q),
      .rd_offset_i (i_rd_addr),
      .rd_data_o   (o_rd_data)
   );

   assign o_frame_valid = (occ_q != '0);
   assign o_frame_len   = slot_len_q[rd_ptr_q];
   assign o_frame_flags = slot_flags_q[rd_ptr_q];
   assign o_drop_count  = drop_cnt_q;
   assign o_busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mii_rx_frame_ring.sv
// tb_mii_rx_frame_ring -- directed scoreboard bench for the MII receive frame ring.
// Rev 1.0
`default_nettype none

module tb_mii_rx_frame_ring;

   localparam int NS = 4;
   localparam int SB = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cap_en = 1'b1;
   logic        dv = 1'b0;
   logic        er = 1'b0;
   logic [3:0]  rxd = 4'h0;
   logic [9:0]  rd_addr = '0;
   logic        rel = 1'b0;
   logic        frame_valid;
   logic [10:0] frame_len;
   logic [2:0]  frame_flags;
   logic [7:0]  rd_data;
   logic [15:0] drop_count;
   logic        busy;

   typedef struct {
      int         len;
      logic [2:0] flags;
      logic [7:0] base;
   } exp_t;

   exp_t sb_q[$];
   int   model_occ = 0;
   int   drop_exp  = 0;
   int   errors    = 0;
   int   checks    = 0;

   mii_rx_frame_ring #(.NUM_SLOTS(NS), .SLOT_BYTES(SB), .STRIP_PREAMBLE(1)) dut (
      .enet_rx_clk   (clk),
      .i_reset       (rst),
      .i_capture_en  (cap_en),
      .enet_rx_dv    (dv),
      .enet_rx_er    (er),
      .enet_rx_data  (rxd),
      .o_frame_valid (frame_valid),
      .o_frame_len   (frame_len),
      .o_frame_flags (frame_flags),
      .i_rd_addr     (rd_addr),
      .o_rd_data     (rd_data),
      .i_release     (rel),
      .o_drop_count  (drop_count),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [7:0] base, input int i);
      return base + 8'(i) + 8'(i >> 8);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic nib(input logic [3:0] n, input logic e = 1'b0);
      @(negedge clk);
      dv = 1'b1; rxd = n; er = e;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         dv = 1'b0; er = 1'b0; rxd = 4'h0;
      end
   endtask

   task automatic preamble();
      repeat (15) nib(4'h5);
      nib(4'hD);
   endtask

   task automatic send_frame(input logic [7:0] base, input int nbytes, input bit extra,
                             input int er_at, input bit rel_at_end);
      exp_t       e;
      logic [7:0] b;
      if (cap_en && model_occ < NS) begin
         e.len   = (nbytes > SB) ? SB : nbytes;
         e.flags = {(er_at >= 0 && er_at < nbytes), extra, (nbytes > SB)};
         e.base  = base;
         sb_q.push_back(e);
         model_occ++;
      end else if (cap_en) begin
         drop_exp++;
      end
      preamble();
      for (int i = 0; i < nbytes; i++) begin
         b = pat(base, i);
         nib(b[3:0], (i == er_at));
         nib(b[7:4]);
      end
      if (extra) nib(4'hA);
      @(negedge clk);
      dv = 1'b0; er = 1'b0;
      if (rel_at_end) begin
         rel = 1'b1;
         void'(sb_q.pop_front());
         model_occ--;
      end
      @(negedge clk);
      rel = 1'b0;
      idle(2);
   endtask

   task automatic check_byte(input int addr, input logic [7:0] expv);
      @(negedge clk);
      rd_addr = 10'(addr);
      @(negedge clk);
      chk($sformatf("rd_byte[%0d]", addr), rd_data, expv);
   endtask

   task automatic check_head();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("valid_empty", frame_valid, 1'b0);
      end else begin
         e = sb_q[0];
         chk("valid", frame_valid, 1'b1);
         chk("len", frame_len, e.len);
         chk("flags", frame_flags, e.flags);
         check_byte(0, pat(e.base, 0));
         if (e.len > 5) check_byte(5, pat(e.base, 5));
         check_byte(e.len - 1, pat(e.base, e.len - 1));
      end
   endtask

   task automatic release_head();
      @(negedge clk);
      rel = 1'b1;
      @(negedge clk);
      rel = 1'b0;
      if (sb_q.size() > 0) begin
         void'(sb_q.pop_front());
         model_occ--;
      end
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", frame_valid, 1'b0);
      chk("rst_len", frame_len, 0);
      chk("rst_flags", frame_flags, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_busy", busy, 1'b0);

      // Basic 64-byte frame after a standard preamble
      send_frame(8'h00, 64, 1'b0, -1, 1'b0);
      check_head();
      release_head();

      // Trailing nibble plus rx_er pulse
      send_frame(8'h80, 20, 1'b1, 7, 1'b0);
      check_head();
      release_head();

      // Broken preamble is dropped without counting
      nib(4'h5); nib(4'h5); nib(4'h3); nib(4'h5);
      chk("drop_busy", busy, 1'b1);
      repeat (3) nib(4'h5);
      idle(2);
      chk("badpre_busy", busy, 1'b0);
      chk("badpre_valid", frame_valid, 1'b0);
      chk("badpre_drop", drop_count, drop_exp);

      // Capture disabled: discarded, not counted
      cap_en = 1'b0;
      send_frame(8'h33, 10, 1'b0, -1, 1'b0);
      cap_en = 1'b1;
      chk("capoff_valid", frame_valid, 1'b0);
      chk("capoff_drop", drop_count, drop_exp);

      // Fill the ring, overflow once, free a slot and refill
      for (int k = 0; k < 5; k++) send_frame(8'(16 * (k + 1)), 8, 1'b0, -1, 1'b0);
      chk("full_drop", drop_count, drop_exp);
      check_head();
      release_head();
      send_frame(8'h60, 8, 1'b0, -1, 1'b0);
      chk("refill_drop", drop_count, drop_exp);
      repeat (4) begin
         check_head();
         release_head();
      end
      check_head();
      release_head();

      // Commit and release on the same edge
      send_frame(8'hA0, 12, 1'b0, -1, 1'b0);
      send_frame(8'hB0, 16, 1'b0, -1, 1'b1);
      check_head();
      release_head();
      check_head();

      // Oversize frame truncates at slot capacity
      send_frame(8'h11, 1100, 1'b0, -1, 1'b0);
      check_head();
      release_head();

      // Reset mid-frame abandons it; next frame lands in slot 0
      send_frame(8'h22, 6, 1'b0, -1, 1'b0);
      preamble();
      repeat (6) nib(4'h7);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
      model_occ = 0;
      drop_exp  = 0;
      nib(4'h1); nib(4'h2);
      chk("postrst_busy", busy, 1'b0);
      chk("postrst_valid", frame_valid, 1'b0);
      chk("postrst_drop", drop_count, 0);
      idle(2);
      chk("postrst_idle_valid", frame_valid, 1'b0);
      send_frame(8'h44, 10, 1'b0, -1, 1'b0);
      check_head();
      release_head();
      check_head();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
